uart_prog_loader: RTL

Boot-time sequencer between the UART receiver and the CPU instruction memory inside cpu_uart_top. It assembles received bytes into little-endian 32-bit instruction words and writes them to consecutive instruction-memory cells. It holds the CPU core in reset until every cell is loaded, then releases the core so fetch starts at address 0.

---
 rtl/uart_prog_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// Boot loader: packs UART bytes into little-endian words, writes them to imem, then releases the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
    parameter int unsigned NUM_WORDS  = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {StRecv, StWrite, StCheck, StDone} state_e;
`else
    typedef enum logic [1:0] {StRecv, StWrite, StDone} state_e;
`endif

    state_e                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRecv;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            StRecv: begin
                if (rx_valid) begin
                    wdata_d[8*byte_idx_q +: 8] = rx_data;
                    byte_idx_d                 = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d                     = csum_q ^ rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (addr_q == LastAddr) begin
`ifdef LOADER_CHECKSUM_EN
                    // A byte arriving during the final write is already the checksum.
                    state_d = StCheck;
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_d = StDone;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`else
                    state_d = StDone;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StRecv;
                    // Lane-0 update commits on the same edge as the write, so the write keeps the old word.
                    if (rx_valid) begin
                        wdata_d[7:0] = rx_data;
                        byte_idx_d   = 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d       = csum_q ^ rx_data;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (rx_valid && !err_q) begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    assign imem_we    = (state_q == StWrite);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = (state_q != StDone);
    assign load_done  = (state_q == StDone);
`ifdef LOADER_CHECKSUM_EN
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

endmodule
